// File: rtl/shift_add_mult8_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the fixed operand/iteration sizes dictated by the 8-bit adder.
package shift_add_mult8_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int MULT_ITER  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

    // Partial product for one iteration: the multiplicand when the current
    // multiplier bit is set, otherwise zero.
    function automatic logic [MULT_WIDTH-1:0] pp_select(
        input logic                  q_lsb,
        input logic [MULT_WIDTH-1:0] mcand
    );
        return q_lsb ? mcand : '0;
    endfunction

endpackage

// File: rtl/shift_add_mult8_if.sv
// Operand/product handshake bundle between a requester (master) and the
// multiplier (slave).
interface shift_add_mult8_if;
    import shift_add_mult8_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [MULT_WIDTH-1:0]     a;
    logic [MULT_WIDTH-1:0]     b;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*MULT_WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/fastadder8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups; the
// group carry ripples between the two halves.
module fastadder8bit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c,
    output logic [7:0] s,
    output logic       cout
);

    function automatic logic [4:0] cla4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       ci
    );
        logic [4:0] cc;
        cc[0] = ci;
        cc[1] = g[0] | (p[0] & ci);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
        cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return cc;
    endfunction

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [4:0] w_c_lo;
    logic [4:0] w_c_hi;

    assign w_g    = x & y;
    assign w_p    = x ^ y;
    assign w_c_lo = cla4(w_g[3:0], w_p[3:0], c);
    assign w_c_hi = cla4(w_g[7:4], w_p[7:4], w_c_lo[4]);

    assign s    = w_p ^ {w_c_hi[3:0], w_c_lo[3:0]};
    assign cout = w_c_hi[4];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one partial-product add
// per clock through fastadder8bit, valid/ready handshakes on both sides.
module shift_add_mult8
    import shift_add_mult8_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITER  = MULT_ITER
) (
    input logic               clk,
    input logic               rst,
    shift_add_mult8_if.slave  s_bus
);

    localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

    mult_state_t       r_state;
    mult_state_t       w_state_nxt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_mcand;
    logic [2:0]        r_cnt;

    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;
    logic              w_in_ready;
    logic              w_out_valid;

    assign w_addend = pp_select(r_q[0], r_mcand);

    fastadder8bit u_adder (
        .x    (r_acc),
        .y    (w_addend),
        .c    (1'b0),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (s_bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (s_bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The adder carry-out lands in acc[7]: {cout,sum,q} shifts right by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_bus.in_valid) begin
                        r_mcand <= s_bus.a;
                        r_q     <= s_bus.b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    {r_acc, r_q} <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                    r_cnt        <= r_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.out_valid = w_out_valid;
    assign s_bus.product   = {r_acc, r_q};

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed testbench for shift_add_mult8 with hand-computed products.
module tb_shift_add_mult8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    shift_add_mult8_if bus ();

    shift_add_mult8 dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for in_ready, presents one operand pair for a single edge, then
    // counts edges until out_valid (lat = -1 on timeout).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [15:0] prod);
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat  = -1;
        prod = 16'hxxxx;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat  = i;
                prod = bus.product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h want 0000", bus.product); end
    endtask

    task automatic test_basic();
        int lat; logic [15:0] p;
        bus.out_ready = 1'b1;
        run_op(8'd13, 8'd11, lat, p);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_checks++; if (p !== 16'h008F) begin n_fail++; $display("FAIL basic_product: got %h want 008f", p); end
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_carry();
        int lat; logic [15:0] p;
        bus.out_ready = 1'b1;
        run_op(8'd255, 8'd255, lat, p);
        n_checks++; if (p !== 16'hFE01) begin n_fail++; $display("FAIL carry_255x255: got %h want fe01", p); end
        @(posedge clk); #1;
        run_op(8'd128, 8'd2, lat, p);
        n_checks++; if (p !== 16'h0100) begin n_fail++; $display("FAIL carry_128x2: got %h want 0100", p); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_identity();
        int lat; logic [15:0] p;
        bus.out_ready = 1'b1;
        run_op(8'd0, 8'd200, lat, p);
        n_checks++; if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_product: got %h want 0000", p); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL zero_latency: got %0d want 8", lat); end
        @(posedge clk); #1;
        run_op(8'd1, 8'hA5, lat, p);
        n_checks++; if (p !== 16'h00A5) begin n_fail++; $display("FAIL identity_product: got %h want 00a5", p); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL identity_latency: got %0d want 8", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] p;
        bus.out_ready = 1'b0;
        run_op(8'd7, 8'd9, lat, p);
        n_checks++; if (p !== 16'h003F) begin n_fail++; $display("FAIL bp_product: got %h want 003f", p); end
        bus.a = 8'd99; bus.b = 8'd99; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_hold[%0d]: got %b want 1", i, bus.out_valid); end
            n_checks++; if (bus.product !== 16'h003F) begin n_fail++; $display("FAIL bp_product_hold[%0d]: got %h want 003f", i, bus.product); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.product !== 16'h003F) begin n_fail++; $display("FAIL bp_product_kept: got %h want 003f", bus.product); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [15:0] p;
        bus.out_ready = 1'b1;
        bus.a = 8'd50; bus.b = 8'd60; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product: got %h want 0000", bus.product); end
        run_op(8'd3, 8'd4, lat, p);
        n_checks++; if (p !== 16'h000C) begin n_fail++; $display("FAIL midrst_next_product: got %h want 000c", p); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] p;
        bus.out_ready = 1'b1;
        bus.a = 8'd12; bus.b = 8'd12; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'd200; bus.b = 8'd3;
        lat = -1; p = 16'hxxxx;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin lat = i; p = bus.product; break; end
        end
        n_checks++; if (p !== 16'h0090) begin n_fail++; $display("FAIL b2b_first_product: got %h want 0090", p); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 8", lat); end
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_between: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1; p = 16'hxxxx;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin lat = i; p = bus.product; break; end
        end
        n_checks++; if (p !== 16'h0258) begin n_fail++; $display("FAIL b2b_second_product: got %h want 0258", p); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_zero_identity();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
